// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, LSB first, one bit per clock
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             bit_s;
    logic             last_bit;

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rs_d     = rs_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        bit_s    = ra_q[0] ^ rb_q[0] ^ c_q;
        last_bit = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // subtraction is a + ~b + 1: invert b and seed the carry
                    ra_d    = a;
                    rb_d    = sub ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                c_d   = (ra_q[0] & rb_q[0]) | (c_q & (ra_q[0] ^ rb_q[0]));
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                rs_d  = {bit_s, rs_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = rs_d;
                    carry_d = c_d;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;

    int total;
    int bad;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            sub   = i[1];
            a     = 8'(i * 53);
            b     = 8'(i * 91);
            step();
            total++;
            if ({busy, done, sum, carry} !== 11'd0) begin
                bad++;
                $display("FAIL reset_hold: busy=%b done=%b sum=%h carry=%b, want all 0", busy, done, sum, carry);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({busy, done, sum, carry} !== 11'd0) begin
                bad++;
                $display("FAIL reset_release: busy=%b done=%b sum=%h carry=%b, want all 0", busy, done, sum, carry);
            end
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                          input logic [7:0] es, input logic ec, input string nm);
        int lat;
        int busy_cnt;
        logic [7:0] prev_sum;
        logic prev_carry;
        prev_sum   = sum;
        prev_carry = carry;
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            total++;
            if (sum !== prev_sum || carry !== prev_carry) begin
                bad++;
                $display("FAIL %s_held: sum=%h carry=%b during run, want %h %b", nm, sum, carry, prev_sum, prev_carry);
            end
            step();
            lat++;
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles, want 8", nm, lat);
        end
        total++;
        if (busy_cnt !== 8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy: busy cycles=%0d busy_at_done=%b, want 8 and 0", nm, busy_cnt, busy);
        end
        total++;
        if (sum !== es || carry !== ec) begin
            bad++;
            $display("FAIL %s_result: sum=%h carry=%b, want sum=%h carry=%b", nm, sum, carry, es, ec);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: done=%b busy=%b after done cycle, want 0 0", nm, done, busy);
        end
    endtask

    task automatic test_add();
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "add_ff_ff");
    endtask

    task automatic test_sub();
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, "sub_10_20");
        run_op(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, "sub_20_10");
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "sub_00_00");
    endtask

    task automatic test_scramble();
        int lat;
        int dones;
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < 20) begin
            start = lat[0];
            sub   = lat[1];
            a     = 8'(lat * 29 + 7);
            b     = 8'(lat * 71 + 3);
            step();
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 8 || sum !== 8'h46 || carry !== 1'b0) begin
            bad++;
            $display("FAIL scramble_result: lat=%0d sum=%h carry=%b, want 8 46 0", lat, sum, carry);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL scramble_restart: %0d extra busy/done cycles, want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL b2b_first: done after %0d cycles, want 9", lat);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_reaccept%0d: busy=%b after done cycle, want 1", k, busy);
            end
            lat = 1;
            while (!done && lat < 20) begin
                step();
                lat++;
            end
            total++;
            if (lat !== 9 || sum !== 8'h02 || carry !== 1'b0) begin
                bad++;
                $display("FAIL b2b_period%0d: period=%0d sum=%h carry=%b, want 9 02 0", k, lat, sum, carry);
            end
        end
        start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 8'hF0; b = 8'h0F; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, carry} !== 11'd0) begin
            bad++;
            $display("FAIL midrun_async: busy=%b done=%b sum=%h carry=%b, want all 0", busy, done, sum, carry);
        end
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_nodone: %0d busy/done cycles after reset, want 0", seen);
        end
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_add();
        test_sub();
        test_scramble();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
